dut_decoder_2to4_seq: RTL and testbench
=======================================

# dut_decoder_2to4_seq

Sequenced 2-to-4 decoder: the decode-side counterpart of the 4-to-2 encoder. It accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line on `y` for a programmable number of cycles. An optional gap follows, then it accepts the next code. It sits between a code source (FSM, encoder output, register) and one-hot select or strobe consumers.

## Interface
- `HOLD`, default 4: cycles `y` stays asserted per accepted code. Legal range 1..255; 0 is treated as 1.
- `GAP`, default 1: idle cycles with `y` = 0 after each hold, before the next accept. Legal range 0..255.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: block enable. Low blocks acceptance and freezes the counters.
- `in_valid` input 1: `code` is valid.
- `in_ready` output 1: block can accept a code.
- `code` input 2: code to decode.
- `y` output 4: registered one-hot output, `4'b0001 << code_q`.
- `y_valid` output 1: high while `y` carries a decoded code.
- `done` output 1: one-cycle pulse on the last HOLD cycle.
- `chk_err` output 1: sticky self-check error. Tied 0 unless `DEC_ENC_CHECK_EN` is defined.

## Operation
- States: IDLE, HOLD, GAP. All outputs are registered except `in_ready`.
- IDLE:
  - `in_ready` = `en`; `y` = 0; `y_valid` = 0.
  - A handshake is `in_valid && in_ready`. On a handshake: latch `code` into `code_q`, load the hold counter with HOLD−1, go to HOLD.
- HOLD:
  - `y` = `4'b0001 << code_q`; `y_valid` = 1; `in_ready` = 0.
  - Counter decrements each cycle `en` = 1.
  - When the counter is 0 and `en` = 1: assert `done` this cycle. Next state is GAP, loaded with GAP−1, if GAP > 0; otherwise IDLE.
- GAP:
  - `y` = 0; `y_valid` = 0; `in_ready` = 0.
  - Counter decrements while `en` = 1. Go to IDLE when the counter is 0 and `en` = 1.
- `en` low in HOLD or GAP freezes the state and counter. `y` holds its value and `done` is suppressed.
- `in_valid` outside IDLE is ignored. The source must hold `code` stable until `in_ready` is seen.
- Decode mapping: 00→0001, 01→0010, 10→0100, 11→1000. It is exactly the inverse of the encoder for one-hot inputs.
- Counters are 8 bits, with no wrap: they load, count down to 0, and stop.

## Timing
- Reset (async assert, sync release) sets:
  - state = IDLE; `y` = 4'b0000; `y_valid` = 0; `done` = 0; `chk_err` = 0; `code_q` = 2'b00; counters = 0.
  - `in_ready` follows `en` from the first post-reset cycle.
- Latency: handshake in cycle N → `y`/`y_valid` valid from cycle N+1 through N+HOLD (with `en` held high).
- `done` is high in cycle N+HOLD only.
- With `en` held high, the next `in_ready` is in cycle N+HOLD+GAP+1.
- Throughput: one code per HOLD+GAP+1 cycles.
- Reset mid-HOLD or mid-GAP:
  - `y` and `y_valid` drop immediately (asynchronous).
  - The in-flight code is discarded; `done` is not issued.
- Handshake in the same cycle `en` falls: no accept, because `in_ready` is already 0.

## Configuration
- `DEC_ENC_CHECK_EN` defined:
  - Every HOLD cycle, `y` is re-encoded with the encoder mapping (0001→00, 0010→01, 0100→10, else 11) and compared with `code_q`.
  - Any mismatch, or `y` not exactly one-hot while `y_valid` = 1, sets `chk_err` on the next clock. It stays set until `rst`.
- `DEC_ENC_CHECK_EN` undefined: the check logic is absent and `chk_err` is constant 0.

## Test plan
- Reset with HOLD=4, GAP=1, `en`=1:
  - `y`=0000, `y_valid`=0, `done`=0, `chk_err`=0, `in_ready`=1.
  - Asserting `rst` mid-HOLD clears `y` without waiting for a clock edge.
- Codes 0,1,2,3 presented back-to-back with `in_valid` held high:
  - `y` = 0001, 0010, 0100, 1000, each for 4 cycles, separated by 1 zero cycle.
  - `done` pulses on the 4th cycle of each hold.
  - Accepts occur every 6 cycles.
- HOLD=1, GAP=0, code 2 accepted in cycle N:
  - `y`=0100 and `done`=1 in cycle N+1; `in_ready`=1 in cycle N+2.
- Code 3 accepted, `en` dropped for 3 cycles during HOLD:
  - `y`=1000 is held 3 extra cycles (7 total); `done` is delayed by 3 cycles.
  - `en`=0 while IDLE keeps `in_ready`=0, and `in_valid` is ignored.
- `in_valid` pulsed with code 1 during HOLD of code 0: ignored, `y` stays 0001, and no second accept occurs.
- With `DEC_ENC_CHECK_EN` defined:
  - Normal traffic over all 4 codes leaves `chk_err`=0.
  - Forcing `y` to 0011 mid-HOLD sets `chk_err`=1 on the next clock; it remains 1 until `rst`.

Source files
------------

// File: rtl/dut_decoder_2to4_seq.sv
// Sequenced 2-to-4 decoder: accepts a code over valid/ready, holds the one-hot line
// for HOLD cycles, idles GAP cycles. Define DEC_ENC_CHECK_EN to build the re-encode self-check.
module dut_decoder_2to4_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] code,
    output logic [3:0] y,
    output logic       y_valid,
    output logic       done,
    output logic       chk_err
);

    // A HOLD of 0 behaves as 1; counters count down to the last cycle of each phase.
    localparam int         HOLD_EFF  = (HOLD < 1) ? 1 : HOLD;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_EFF - 1);
    localparam logic [7:0] GAP_LOAD  = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam bit         HAS_GAP   = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic [1:0] code_reg;
    logic [3:0] y_reg;
    logic       y_valid_reg;
    logic       done_reg;
    logic [3:0] dec_code;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
        assign dec_code[gi] = (code == 2'(gi));
    end

    assign in_ready = en && (state_reg == ST_IDLE);
    assign y        = y_reg;
    assign y_valid  = y_valid_reg;
    assign done     = done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 8'd0;
            code_reg    <= 2'b00;
            y_reg       <= 4'b0000;
            y_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        code_reg    <= code;
                        cnt_reg     <= HOLD_LOAD;
                        y_reg       <= dec_code;
                        y_valid_reg <= 1'b1;
                        done_reg    <= (HOLD_LOAD == 8'd0);
                        state_reg   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (en) begin
                        if (cnt_reg == 8'd0) begin
                            y_reg       <= 4'b0000;
                            y_valid_reg <= 1'b0;
                            cnt_reg     <= GAP_LOAD;
                            state_reg   <= HAS_GAP ? ST_GAP : ST_IDLE;
                        end else begin
                            cnt_reg  <= cnt_reg - 8'd1;
                            // done is registered, so it is raised on entry to the last hold cycle
                            done_reg <= (cnt_reg == 8'd1);
                        end
                    end
                end
                ST_GAP: begin
                    if (en) begin
                        if (cnt_reg == 8'd0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DEC_ENC_CHECK_EN
    logic [1:0] enc_y;
    logic       y_one_hot;
    logic       chk_err_reg;

    always_comb begin
        enc_y = 2'b11;
        case (y_reg)
            4'b0001: enc_y = 2'b00;
            4'b0010: enc_y = 2'b01;
            4'b0100: enc_y = 2'b10;
            default: enc_y = 2'b11;
        endcase
    end

    assign y_one_hot = (y_reg != 4'b0000) && ((y_reg & (y_reg - 4'd1)) == 4'b0000);

    // Sticky until reset: any hold cycle whose output does not round-trip through the encoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_reg <= 1'b0;
        end else if (y_valid_reg && ((enc_y != code_reg) || !y_one_hot)) begin
            chk_err_reg <= 1'b1;
        end
    end

    assign chk_err = chk_err_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_dut_decoder_2to4_seq.sv
// Randomized bench for dut_decoder_2to4_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked each cycle against a position-in-transaction reference model.
module tb_dut_decoder_2to4_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] code = 2'b00;

    logic       in_ready_a, y_valid_a, done_a, chk_err_a;
    logic [3:0] y_a;
    logic       in_ready_b, y_valid_b, done_b, chk_err_b;
    logic [3:0] y_b;

    int checks = 0;
    int errors = 0;

    // reference model: per instance, whether a code is in flight and which output cycle we are in
    int         hold_p[2] = '{4, 1};
    int         gap_p[2]  = '{1, 0};
    bit         busy[2];
    int         pos[2];
    bit         adv[2];
    logic [1:0] mcode[2];
    logic       exp_chk = 1'b0;
    int         y8_cnt;
    int         acc_cnt;

    always #5 clk = ~clk;

    dut_decoder_2to4_seq #(.HOLD(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_a),
        .code(code), .y(y_a), .y_valid(y_valid_a), .done(done_a), .chk_err(chk_err_a)
    );

    dut_decoder_2to4_seq #(.HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_b),
        .code(code), .y(y_b), .y_valid(y_valid_b), .done(done_b), .chk_err(chk_err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy[i]  = 1'b0;
            pos[i]   = 0;
            adv[i]   = 1'b0;
            mcode[i] = 2'b00;
        end
        exp_chk = 1'b0;
    endtask

    function automatic logic [3:0] exp_y(input int i);
        return (busy[i] && pos[i] <= hold_p[i]) ? (4'b0001 << mcode[i]) : 4'b0000;
    endfunction

    task automatic compare_all();
        check_eq("a_y",       {28'd0, y_a},        {28'd0, exp_y(0)});
        check_eq("a_y_valid", {31'd0, y_valid_a},  {31'd0, busy[0] && pos[0] <= hold_p[0]});
        check_eq("a_done",    {31'd0, done_a},     {31'd0, busy[0] && pos[0] == hold_p[0] && adv[0]});
        check_eq("a_in_ready",{31'd0, in_ready_a}, {31'd0, en && !busy[0]});
        check_eq("a_chk_err", {31'd0, chk_err_a},  {31'd0, exp_chk});
        check_eq("b_y",       {28'd0, y_b},        {28'd0, exp_y(1)});
        check_eq("b_y_valid", {31'd0, y_valid_b},  {31'd0, busy[1] && pos[1] <= hold_p[1]});
        check_eq("b_done",    {31'd0, done_b},     {31'd0, busy[1] && pos[1] == hold_p[1] && adv[1]});
        check_eq("b_in_ready",{31'd0, in_ready_b}, {31'd0, en && !busy[1]});
        check_eq("b_chk_err", {31'd0, chk_err_b},  {31'd0, 1'b0});
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            adv[i] = 1'b0;
            if (!busy[i] && en && in_valid) begin
                busy[i]  = 1'b1;
                pos[i]   = 1;
                adv[i]   = 1'b1;
                mcode[i] = code;
                if (i == 0) acc_cnt++;
                $display("accept dut%0d code=%0d at %0t", i, code, $time);
            end else if (busy[i] && en) begin
                pos[i]++;
                adv[i] = 1'b1;
                if (pos[i] > hold_p[i] + gap_p[i]) busy[i] = 1'b0;
            end
        end
    endtask

    // called just after a rising edge: drive, compare mid-cycle, advance the model at the edge
    task automatic run_cycle(input logic v, input logic [1:0] c, input logic e);
        in_valid = v;
        code     = c;
        en       = e;
        @(negedge clk);
        compare_all();
        if (y_a == 4'b1000) y8_cnt++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_y",       {28'd0, y_a},       32'd0);
        check_eq("rst_y_valid", {31'd0, y_valid_a}, 32'd0);
        check_eq("rst_done",    {31'd0, done_a},    32'd0);
        check_eq("rst_chk_err", {31'd0, chk_err_a}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle(1'b0, 2'b00, 1'b1);
        check_eq("rst_in_ready", {31'd0, in_ready_a}, 32'd1);

        // back-to-back codes 0..3, in_valid held high: four accepts in 24 cycles
        acc_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) run_cycle(1'b1, 2'(k), 1'b1);
        end
        check_eq("b2b_accepts", acc_cnt, 32'd4);
        for (int j = 0; j < 6; j++) run_cycle(1'b0, 2'b00, 1'b1);

        // en low while idle blocks acceptance
        for (int j = 0; j < 3; j++) run_cycle(1'b1, 2'b01, 1'b0);

        // code 3 with en dropped for 3 hold cycles stretches y to 7 cycles
        do_reset();
        y8_cnt = 0;
        run_cycle(1'b1, 2'b11, 1'b1);
        run_cycle(1'b0, 2'b11, 1'b1);
        run_cycle(1'b0, 2'b11, 1'b1);
        for (int j = 0; j < 3; j++) run_cycle(1'b0, 2'b11, 1'b0);
        for (int j = 0; j < 6; j++) run_cycle(1'b0, 2'b11, 1'b1);
        check_eq("hold_ext", y8_cnt, 32'd7);

        // in_valid with code 1 during hold of code 0 is ignored
        do_reset();
        acc_cnt = 0;
        run_cycle(1'b1, 2'b00, 1'b1);
        for (int j = 0; j < 3; j++) run_cycle(1'b1, 2'b01, 1'b1);
        run_cycle(1'b0, 2'b01, 1'b1);
        check_eq("ignore_accepts", acc_cnt, 32'd1);

        // randomized traffic
        for (int j = 0; j < 400; j++) begin
            run_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 9) != 0));
        end

        // asynchronous reset mid-hold clears y before any clock edge
        do_reset();
        run_cycle(1'b1, 2'b11, 1'b1);
        run_cycle(1'b0, 2'b11, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_y",       {28'd0, y_a},       32'd0);
        check_eq("async_rst_y_valid", {31'd0, y_valid_a}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 8; j++) run_cycle(1'b0, 2'b00, 1'b1);

`ifdef DEC_ENC_CHECK_EN
        // traffic over all codes leaves chk_err clear; a corrupted y sets it sticky
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) run_cycle(1'b1, 2'(k), 1'b1);
        end
        run_cycle(1'b1, 2'b00, 1'b1);
        in_valid = 1'b0;
        force dut.y_reg = 4'b0011;
        @(posedge clk);
        #1;
        release dut.y_reg;
        check_eq("chk_err_set", {31'd0, chk_err_a}, 32'd1);
        for (int j = 0; j < 10; j++) @(posedge clk);
        #1;
        check_eq("chk_err_sticky", {31'd0, chk_err_a}, 32'd1);
        do_reset();
        run_cycle(1'b0, 2'b00, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
